class_clock_scheduler: RTL and testbench

- Synchronous game-time controller for the classroom game.
- Owns the prescaler and the minutes counter that feed the SSD minutes digits and the game FSM `minutes` input.
- Pauses time while a quiz runs, freezes it on win/lose, and schedules professor quiz requests at a fixed minute interval through a req/ack handshake.
- Sits between the top-level clock and the main game FSM. It replaces any divided-clock or ripple timer with single-clock enables.

---
 rtl/fpsr_pkg.sv | 20 ++
 rtl/class_clock_scheduler_if.sv | 26 ++
 rtl/tick_prescaler.sv | 31 +++
 rtl/class_clock_scheduler.sv | 119 +++++++++++
 tb/tb_class_clock_scheduler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpsr_pkg.sv
// Shared definitions for the classroom game timing blocks: scheduler state
// encodings, default timing constants and the quiz-interval predicate.
package fpsr_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_PAUSE = 2'd2,
    SCHED_DONE  = 2'd3
  } sched_state_t;

  localparam int TICK_DIV_DEFAULT = 67108864;
  localparam int END_MIN_DEFAULT  = 60;

  // A quiz is due on every nonzero multiple of the period; a zero period disables quizzes.
  function automatic logic quiz_due(input int minute, input int period);
    return (period > 0) && (minute != 0) && ((minute % period) == 0);
  endfunction

endpackage

// File: rtl/class_clock_scheduler_if.sv
// Control and status bundle between the main game FSM and the clock scheduler.
interface class_clock_scheduler_if #(
  parameter int MIN_W = 8
);
  logic             init;
  logic             run;
  logic             freeze;
  logic             quiz_active;
  logic             quiz_done;
  logic             quiz_ack;
  logic [MIN_W-1:0] minutes;
  logic             tick;
  logic             quiz_req;
  logic             time_up;
  logic [1:0]       sched_state;

  modport master (
    output init, run, freeze, quiz_active, quiz_done, quiz_ack,
    input  minutes, tick, quiz_req, time_up, sched_state
  );

  modport slave (
    input  init, run, freeze, quiz_active, quiz_done, quiz_ack,
    output minutes, tick, quiz_req, time_up, sched_state
  );
endinterface

// File: rtl/tick_prescaler.sv
// Game-minute prescaler: counts enabled cycles and flags the terminal count
// so the owner can issue a single-cycle minute enable on the wrap.
module tick_prescaler #(
  parameter int TICK_DIV = 67108864,
  parameter int TICK_W   = 27
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] count_q;

  // Terminal count is reported independent of en; the owner gates it.
  assign wrap = (count_q == LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= wrap ? '0 : count_q + TICK_W'(1);
    end
  end

endmodule

// File: rtl/class_clock_scheduler.sv
// Game-time controller: minute prescaling, pause/freeze control and
// periodic professor-quiz requests, all on a single clock with enables.
module class_clock_scheduler
  import fpsr_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int TICK_W      = 27,
  parameter int MIN_W       = 8,
  parameter int QUIZ_PERIOD = 4,
  parameter int END_MIN     = END_MIN_DEFAULT
) (
  input logic                     Clk,
  input logic                     Reset,
  class_clock_scheduler_if.slave  bus
);

  sched_state_t     state_q, state_d;
  logic [MIN_W-1:0] minutes_q, minutes_d, minutes_inc;
  logic             tick_q, tick_d;
  logic             req_q, req_d;
  logic             tup_q, tup_d;
  logic             pres_clr, pres_en, pres_wrap;
  logic             quiz_due_now;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_prescaler (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (pres_clr),
    .en    (pres_en),
    .wrap  (pres_wrap)
  );

  assign minutes_inc = minutes_q + MIN_W'(1);

  always_comb begin
    state_d      = state_q;
    minutes_d    = minutes_q;
    tick_d       = 1'b0;
    tup_d        = tup_q;
    pres_clr     = 1'b0;
    pres_en      = 1'b0;
    quiz_due_now = 1'b0;

    if (bus.init) begin
      state_d   = SCHED_IDLE;
      minutes_d = '0;
      tup_d     = 1'b0;
      pres_clr  = 1'b1;
    end else begin
      unique case (state_q)
        SCHED_IDLE: begin
          pres_clr  = 1'b1;
          minutes_d = '0;
          if (bus.run) state_d = SCHED_RUN;
        end
        SCHED_RUN: begin
          // A pause or freeze request stalls the prescaler, so no tick can slip out.
          if (bus.freeze) begin
            state_d = SCHED_DONE;
          end else if (bus.quiz_active) begin
            state_d = SCHED_PAUSE;
          end else begin
            pres_en = 1'b1;
            if (pres_wrap) begin
              tick_d    = 1'b1;
              minutes_d = minutes_inc;
              if (minutes_inc == MIN_W'(END_MIN)) begin
                tup_d   = 1'b1;
                state_d = SCHED_DONE;
              end else begin
                quiz_due_now = quiz_due(int'(minutes_inc), QUIZ_PERIOD);
              end
            end
          end
        end
        SCHED_PAUSE: begin
          if (bus.freeze)         state_d = SCHED_DONE;
          else if (bus.quiz_done) state_d = SCHED_RUN;
        end
        SCHED_DONE: begin
          state_d = SCHED_DONE;
        end
        default: state_d = SCHED_IDLE;
      endcase
    end

    // A newly due quiz beats a simultaneous acknowledge of the previous one.
    if (bus.init)         req_d = 1'b0;
    else if (quiz_due_now) req_d = 1'b1;
    else if (bus.quiz_ack) req_d = 1'b0;
    else                   req_d = req_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= SCHED_IDLE;
      minutes_q <= '0;
      tick_q    <= 1'b0;
      req_q     <= 1'b0;
      tup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      minutes_q <= minutes_d;
      tick_q    <= tick_d;
      req_q     <= req_d;
      tup_q     <= tup_d;
    end
  end

  assign bus.minutes     = minutes_q;
  assign bus.tick        = tick_q;
  assign bus.quiz_req    = req_q;
  assign bus.time_up     = tup_q;
  assign bus.sched_state = state_q;

endmodule

// File: tb/tb_class_clock_scheduler.sv
// Scoreboard bench for class_clock_scheduler: directed scenarios followed by
// random control traffic, checked against a rule-level model of game time.
module tb_class_clock_scheduler;

  localparam int TD = 4;
  localparam int TW = 3;
  localparam int MW = 8;
  localparam int QP = 2;
  localparam int EM = 5;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  class_clock_scheduler_if #(.MIN_W(MW)) bus();

  class_clock_scheduler #(
    .TICK_DIV    (TD),
    .TICK_W      (TW),
    .MIN_W       (MW),
    .QUIZ_PERIOD (QP),
    .END_MIN     (EM)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int minutes;
    int tick;
    int req;
    int tup;
    int st;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: game phase, cycles into the current minute, and outputs.
  int m_st   = ST_IDLE;
  int m_pres = 0;
  int m_min  = 0;
  int m_tick = 0;
  int m_req  = 0;
  int m_tup  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_pres = 0; m_min = 0; m_tick = 0; m_req = 0; m_tup = 0;
  endtask

  // One clock of game time, computed from the game rules.
  task automatic model_step(input bit i, input bit r, input bit f, input bit qa,
                            input bit qd, input bit ak);
    bit due;
    due    = 1'b0;
    m_tick = 0;
    if (i) begin
      model_reset();
      return;
    end
    if (m_st == ST_IDLE) begin
      m_pres = 0;
      if (r) m_st = ST_RUN;
    end else if (m_st == ST_RUN) begin
      if (f) m_st = ST_DONE;
      else if (qa) m_st = ST_PAUSE;
      else begin
        m_pres = m_pres + 1;
        if (m_pres == TD) begin
          m_pres = 0;
          m_min  = m_min + 1;
          m_tick = 1;
          if (m_min == EM) begin
            m_tup = 1;
            m_st  = ST_DONE;
          end else begin
            due = (m_min % QP) == 0;
          end
        end
      end
    end else if (m_st == ST_PAUSE) begin
      if (f) m_st = ST_DONE;
      else if (qd) m_st = ST_RUN;
    end
    if (due) m_req = 1;
    else if (ak) m_req = 0;
  endtask

  // Called at a falling edge: apply inputs, record the expectation, advance to the next falling edge.
  task automatic step(input bit i, input bit r, input bit f, input bit qa,
                      input bit qd, input bit ak);
    exp_t e;
    bus.init = i; bus.run = r; bus.freeze = f;
    bus.quiz_active = qa; bus.quiz_done = qd; bus.quiz_ack = ak;
    model_step(i, r, f, qa, qd, ak);
    e.minutes = m_min; e.tick = m_tick; e.req = m_req; e.tup = m_tup; e.st = m_st;
    exp_q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_minutes"}, 32'(bus.minutes), 0);
    check({tag, "_tick"}, 32'(bus.tick), 0);
    check({tag, "_quiz_req"}, 32'(bus.quiz_req), 0);
    check({tag, "_time_up"}, 32'(bus.time_up), 0);
    check({tag, "_state"}, 32'(bus.sched_state), ST_IDLE);
  endtask

  // Called at a falling edge: asynchronous reset pulse between clock edges.
  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b1;
    #1;
    check_all_zero(tag);
    @(negedge Clk);
    bus.init = 0; bus.run = 0; bus.freeze = 0;
    bus.quiz_active = 0; bus.quiz_done = 0; bus.quiz_ack = 0;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic run_until_pres3();
    for (int k = 0; k < 50 && !(m_st == ST_RUN && m_pres == TD - 1); k++) idle_step();
    if (!(m_st == ST_RUN && m_pres == TD - 1)) begin
      errors++;
      $display("FAIL reach_prescaler_last actual_state=%0d required_state=%0d", m_st, ST_RUN);
    end
  endtask

  task automatic run_until_min(input int target);
    for (int k = 0; k < 200 && m_min != target; k++) idle_step();
    if (m_min != target) begin
      errors++;
      $display("FAIL reach_minutes actual=%0d required=%0d", m_min, target);
    end
  endtask

  // Monitor: compare every registered output shortly after each rising edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("minutes", 32'(bus.minutes), e.minutes);
      check("tick", 32'(bus.tick), e.tick);
      check("quiz_req", 32'(bus.quiz_req), e.req);
      check("time_up", 32'(bus.time_up), e.tup);
      check("sched_state", 32'(bus.sched_state), e.st);
    end
  end

  initial begin
    bus.init = 0; bus.run = 0; bus.freeze = 0;
    bus.quiz_active = 0; bus.quiz_done = 0; bus.quiz_ack = 0;

    @(negedge Clk);
    #1;
    check_all_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Start, first minute, quiz request and acknowledge.
    step(0, 1, 0, 0, 0, 0);
    run_until_min(2);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Quiz pause on the terminal prescaler count, long hold, then resume.
    run_until_pres3();
    step(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    idle_step();

    // Run out the clock with the minute-4 quiz already acknowledged.
    run_until_min(4);
    step(0, 0, 0, 0, 0, 1);
    run_until_min(EM);
    for (int k = 0; k < 20; k++) idle_step();
    step(1, 0, 0, 0, 0, 0);
    idle_step();

    // Freeze beats quiz_done in PAUSE.
    step(0, 1, 0, 0, 0, 0);
    idle_step();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    idle_step();
    step(1, 0, 0, 0, 0, 0);

    // Freeze on the terminal prescaler count suppresses the tick.
    step(0, 1, 0, 0, 0, 0);
    run_until_pres3();
    step(0, 0, 1, 0, 0, 0);
    idle_step();
    step(1, 0, 0, 0, 0, 0);

    // Asynchronous reset with a pending quiz request at minute 3.
    step(0, 1, 0, 0, 0, 0);
    run_until_min(3);
    async_reset("async_reset");

    // Random control traffic.
    for (int n = 0; n < 1500; n++) begin
      bit i, r, f, qa, qd, ak;
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rand_reset");
      end else begin
        i  = ($urandom_range(0, 79) == 0);
        r  = ($urandom_range(0, 1) == 0);
        f  = ($urandom_range(0, 59) == 0);
        qa = ($urandom_range(0, 5) == 0);
        qd = ($urandom_range(0, 3) == 0);
        ak = ($urandom_range(0, 3) == 0);
        step(i, r, f, qa, qd, ak);
      end
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
